// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between writeback and the MDU, with a
// starvation guard and a pending-destination scoreboard for decode interlock.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_rd_data,
  input  logic        wb_rd_wen,
  output logic        wb_stall,
  input  logic        mdu_issue,
  input  logic [4:0]  mdu_issue_rd,
  input  logic        mdu_vld,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_rdy,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] sb_busy,
  output logic        sb_err
);

  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

  localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

  state_t      state, state_nxt;
  logic [3:0]  starve_cnt, cnt_nxt;
  logic        a_req, force_b, grant_a;
  logic [31:0] set_vec, clr_vec;
  logic        err_issue, err_waw;

  assign a_req   = wb_rd_wen && (wb_rd != 5'd0);
  assign force_b = (state == FORCE) && mdu_vld;
  assign grant_a = a_req && !force_b;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= cnt_nxt;
    end
  end

  // A refusal can only happen in IDLE or WAIT; the IDLE refusal is counted
  // too, so STARVE_LIMIT refusals lead to FORCE (even for a limit of 1).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = starve_cnt;
    mdu_rdy   = mdu_vld && (!a_req || force_b);
    wb_stall  = a_req && force_b;
    if (!mdu_vld || mdu_rdy) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (starve_cnt == LIMIT_M1) begin
      state_nxt = FORCE;
      cnt_nxt   = '0;
    end else begin
      state_nxt = WAIT;
      cnt_nxt   = starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (grant_a) begin
      rf_wen   <= 1'b1;
      rf_waddr <= wb_rd;
      rf_wdata <= wb_rd_data;
    end else if (mdu_rdy && (mdu_rd != 5'd0)) begin
      rf_wen   <= 1'b1;
      rf_waddr <= mdu_rd;
      rf_wdata <= mdu_data;
    end else begin
      rf_wen   <= 1'b0;
    end
  end

  // Set is applied after clear so a same-index issue wins over the retiring result.
  assign set_vec   = (mdu_issue && (mdu_issue_rd != 5'd0)) ? (32'd1 << mdu_issue_rd) : '0;
  assign clr_vec   = mdu_rdy ? (32'd1 << mdu_rd) : '0;
  assign err_issue = mdu_issue && (mdu_issue_rd != 5'd0) && sb_busy[mdu_issue_rd]
                     && !clr_vec[mdu_issue_rd];
  assign err_waw   = grant_a && sb_busy[wb_rd];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sb_busy <= '0;
      sb_err  <= 1'b0;
    end else begin
      sb_busy <= (sb_busy & ~clr_vec) | set_vec;
      if (err_issue || err_waw) sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: stimulus queues expected port writes,
// a negedge monitor pops them whenever rf_wen is seen.
module tb_wb_port_arbiter;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [4:0]  wb_rd;
  logic [31:0] wb_rd_data;
  logic        wb_rd_wen;
  logic        wb_stall;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_rd;
  logic        mdu_vld;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_rdy;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] sb_busy;
  logic        sb_err;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .wb_rd(wb_rd), .wb_rd_data(wb_rd_data), .wb_rd_wen(wb_rd_wen), .wb_stall(wb_stall),
    .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd),
    .mdu_vld(mdu_vld), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_rdy(mdu_rdy),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .sb_busy(sb_busy), .sb_err(sb_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write seen on the port must match the oldest expected write.
  always @(negedge CLK) begin
    if (RSTN === 1'b1 && rf_wen === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %h expected none", rf_waddr, rf_wdata);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== e) begin
          errors++;
          $display("FAIL rf_write: got addr %0d data %h expected addr %0d data %h",
                   rf_waddr, rf_wdata, e[36:32], e[31:0]);
        end
      end
    end
  end

  // One clock cycle of stimulus; the expected grant outcome is given by hand.
  task automatic cycle(input string name,
                       input logic wen, input logic [4:0] wrd, input logic [31:0] wdat,
                       input logic iss, input logic [4:0] ird,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                       input logic exp_rdy, input logic exp_stall);
    @(posedge CLK);
    #1;
    wb_rd_wen = wen; wb_rd = wrd; wb_rd_data = wdat;
    mdu_issue = iss; mdu_issue_rd = ird;
    mdu_vld = mv; mdu_rd = mrd; mdu_data = mdat;
    if (wen && wrd != 5'd0 && !exp_stall) exp_q.push_back({wrd, wdat});
    else if (exp_rdy && mrd != 5'd0) exp_q.push_back({mrd, mdat});
    #1;
    chk({name, "_mdu_rdy"}, 32'(mdu_rdy), 32'(exp_rdy));
    chk({name, "_wb_stall"}, 32'(wb_stall), 32'(exp_stall));
  endtask

  task automatic idle(input string name);
    cycle(name, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    RSTN = 1'b0;
    wb_rd_wen = 1'b0; wb_rd = '0; wb_rd_data = '0;
    mdu_issue = 1'b0; mdu_issue_rd = '0;
    mdu_vld = 1'b0; mdu_rd = '0; mdu_data = '0;
    #12;
    chk("rst_rf_wen", 32'(rf_wen), 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_sb_busy", sb_busy, 32'd0);
    chk("rst_sb_err", 32'(sb_err), 32'd0);
    chk("rst_wb_stall", 32'(wb_stall), 32'd0);
    chk("rst_mdu_rdy", 32'(mdu_rdy), 32'd0);
    @(negedge CLK);
    RSTN = 1'b1;

    // Writeback only
    cycle("wb_only", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    idle("wb_only_idle");

    // MDU granted in an idle writeback slot; scoreboard bit 7 goes 0->1->0
    chk("sb7_before", 32'(sb_busy[7]), 32'd0);
    cycle("issue7", 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    cycle("mdu7", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h12345678, 1'b1, 1'b0);
    chk("sb7_set", 32'(sb_busy[7]), 32'd1);
    idle("mdu7_idle");
    chk("sb7_clear", 32'(sb_busy[7]), 32'd0);

    // Starvation: 4 refusals, forced grant with stall, then held writeback
    for (int unsigned i = 0; i < 4; i++)
      cycle("starve_ref", 1'b1, 5'd3, 32'hA0A0A0A0, 1'b0, 5'd0, 1'b1, 5'd9, 32'hB9B9B9B9, 1'b0, 1'b0);
    cycle("starve_force", 1'b1, 5'd3, 32'hA0A0A0A0, 1'b0, 5'd0, 1'b1, 5'd9, 32'hB9B9B9B9, 1'b1, 1'b1);
    cycle("starve_held", 1'b1, 5'd3, 32'hA0A0A0A0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    idle("starve_idle");
    chk("starve_sb_err", 32'(sb_err), 32'd0);

    // x0 handling
    cycle("wb_x0", 1'b1, 5'd0, 32'h11111111, 1'b0, 5'd0, 1'b1, 5'd10, 32'hC0C0C0C0, 1'b1, 1'b0);
    cycle("mdu_x0", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hEEEEEEEE, 1'b1, 1'b0);
    idle("x0_idle");
    chk("x0_sb_busy", sb_busy, 32'd0);

    // Set/clear race on rd=4
    cycle("issue4", 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    cycle("race4", 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd4, 32'hD4D4D4D4, 1'b1, 1'b0);
    idle("race_idle");
    chk("race_sb_busy", sb_busy, 32'h0000_0010);
    chk("race_sb_err", 32'(sb_err), 32'd0);

    // WAW violation: writeback to busy x4
    cycle("waw4", 1'b1, 5'd4, 32'hE4E4E4E4, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    idle("waw_idle1");
    chk("waw_sb_err", 32'(sb_err), 32'd1);
    idle("waw_idle2");
    chk("waw_sb_err_sticky", 32'(sb_err), 32'd1);

    // Reset in the middle of WAIT
    cycle("pre_rst1", 1'b1, 5'd3, 32'h33333333, 1'b0, 5'd0, 1'b1, 5'd9, 32'h99999999, 1'b0, 1'b0);
    cycle("pre_rst2", 1'b1, 5'd3, 32'h33333333, 1'b0, 5'd0, 1'b1, 5'd9, 32'h99999999, 1'b0, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    #1;
    RSTN = 1'b0;
    #1;
    chk("arst_rf_wen", 32'(rf_wen), 32'd0);
    chk("arst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("arst_rf_wdata", rf_wdata, 32'd0);
    chk("arst_sb_busy", sb_busy, 32'd0);
    chk("arst_sb_err", 32'(sb_err), 32'd0);
    chk("arst_wb_stall", 32'(wb_stall), 32'd0);
    wb_rd_wen = 1'b0; mdu_vld = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;

    // A full fresh count after reset shows the FSM restarted from IDLE
    for (int unsigned i = 0; i < 4; i++)
      cycle("post_rst_ref", 1'b1, 5'd11, 32'h0B0B0B0B, 1'b0, 5'd0, 1'b1, 5'd12, 32'h0C0C0C0C, 1'b0, 1'b0);
    cycle("post_rst_force", 1'b1, 5'd11, 32'h0B0B0B0B, 1'b0, 5'd0, 1'b1, 5'd12, 32'h0C0C0C0C, 1'b1, 1'b1);
    cycle("post_rst_held", 1'b1, 5'd11, 32'h0B0B0B0B, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    idle("end_idle1");
    idle("end_idle2");
    chk("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
